// File: rtl/cpu_mem_arbiter_if.sv
// CPU fetch/data ports and the unified single-port memory bus, grouped for the arbiter.
// Requests are held with their fields until the matching gnt pulse; rvalid is a one-cycle response strobe.
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic [1:0]        if_exc;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [1:0]        d_exc;

  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_gnt, if_rvalid, if_rdata, if_exc, d_gnt, d_rvalid, d_rdata, d_exc,
    output mem_read, mem_write, mem_size, mem_addr, mem_wdata
  );

  // CPU and memory side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_gnt, if_rvalid, if_rdata, if_exc, d_gnt, d_rvalid, d_rdata, d_exc,
    input  mem_read, mem_write, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port memory between CPU fetch and data ports, one transaction at a time,
// with alignment checking, a fetch-starvation limit and an access timeout.
module cpu_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             reset,
  cpu_mem_arbiter_if.slave bus,
  output logic [1:0]       state_o
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q;
  logic [TW-1:0]     timer_q;
  logic              src_d_q, we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic [1:0]        if_exc_q, d_exc_q;

  logic              d_win, grant, misaligned, timed_out, load_resp, resp_to_d;
  logic [1:0]        sel_size;
  logic [2:0]        sel_addr_lo, size_mask;
  logic [1:0]        resp_exc_d;
  logic [DATA_W-1:0] resp_rdata_d;

  always_comb begin
    // Data normally wins; a pending fetch takes over once the data streak hits its limit.
    d_win       = bus.d_req && !(bus.if_req && (streak_q == SW'(MAX_D_STREAK)));
    grant       = (state_q == IDLE) && (bus.d_req || bus.if_req) && !reset;
    sel_size    = d_win ? bus.d_size : 2'b11;
    sel_addr_lo = d_win ? bus.d_addr[2:0] : bus.if_addr[2:0];
    case (sel_size)
      2'b00:   size_mask = 3'b000;
      2'b01:   size_mask = 3'b001;
      2'b10:   size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
    misaligned = (sel_addr_lo & size_mask) != 3'b000;
    timed_out  = (timer_q == TW'(TIMEOUT - 1));
    resp_to_d  = (state_q == IDLE) ? d_win : src_d_q;

    state_d      = state_q;
    load_resp    = 1'b0;
    resp_exc_d   = 2'b00;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          if (misaligned) begin
            state_d    = RESP;
            load_resp  = 1'b1;
            resp_exc_d = 2'b01;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          state_d      = RESP;
          load_resp    = 1'b1;
          resp_rdata_d = we_q ? '0 : bus.mem_rdata;
        end else if (timed_out) begin
          state_d    = RESP;
          load_resp  = 1'b1;
          resp_exc_d = 2'b11;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      timer_q    <= '0;
      src_d_q    <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      if_exc_q   <= 2'b00;
      d_rdata_q  <= '0;
      d_exc_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      timer_q <= (state_q == ACCESS) ? timer_q + TW'(1) : '0;
      if (!bus.if_req)         streak_q <= '0;
      else if (grant && d_win) streak_q <= streak_q + SW'(1);
      else if (grant)          streak_q <= '0;
      if (grant) begin
        src_d_q <= d_win;
        we_q    <= d_win && bus.d_we;
        size_q  <= sel_size;
        addr_q  <= d_win ? bus.d_addr : bus.if_addr;
        wdata_q <= d_win ? bus.d_wdata : '0;
      end
      if (load_resp) begin
        if (resp_to_d) begin
          d_rdata_q <= resp_rdata_d;
          d_exc_q   <= resp_exc_d;
        end else begin
          if_rdata_q <= resp_rdata_d;
          if_exc_q   <= resp_exc_d;
        end
      end
    end
  end

  assign bus.d_gnt     = grant && d_win;
  assign bus.if_gnt    = grant && !d_win;
  assign bus.d_rvalid  = (state_q == RESP) && src_d_q;
  assign bus.if_rvalid = (state_q == RESP) && !src_d_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_exc     = d_exc_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_exc    = if_exc_q;
  assign bus.mem_read  = (state_q == ACCESS) && !we_q;
  assign bus.mem_write = (state_q == ACCESS) && we_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign state_o       = state_q;
endmodule
